// File: rtl/toeplitz_pkg.sv
// Shared constants and state encoding for the toeplitz extractor and its scheduler.
package toeplitz_pkg;

    localparam int unsigned ToepN  = 256;  // raw bits per block
    localparam int unsigned ToepL  = 128;  // extracted bits per block
    localparam int unsigned ToepBs = 1;    // bits fed to the core per cycle (serial)

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StPrime,
        StStream,
        StWaitq
    } tsched_state_t;

endpackage

// File: rtl/toeplitz_bitbuf.sv
// N-bit block buffer: shifts raw bits in at the LSB, shifts them out MSB first.
// The counter tracks bits loaded (fill) or bits emitted (stream) and is cleared by the owner.
module toeplitz_bitbuf
    import toeplitz_pkg::*;
#(
    parameter int unsigned N    = ToepN,
    parameter int unsigned CntW = $clog2(N + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            load_i,
    input  logic            bit_i,
    input  logic            shift_i,
    input  logic            clr_i,
    output logic            msb_o,
    output logic [CntW-1:0] cnt_o
);

    logic [N-1:0]    buf_q, buf_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Next-state: load and shift share the same left shift; clear only touches the counter.
    always_comb begin
        buf_d = buf_q;
        cnt_d = cnt_q;
        if (load_i) begin
            buf_d = {buf_q[N-2:0], bit_i};
            cnt_d = cnt_q + CntW'(1);
        end else if (shift_i) begin
            buf_d = {buf_q[N-2:0], 1'b0};
            cnt_d = cnt_q + CntW'(1);
        end
        if (clr_i) begin
            cnt_d = '0;
        end
    end

    // Buffer and counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            buf_q <= '0;
            cnt_q <= '0;
        end else begin
            buf_q <= buf_d;
            cnt_q <= cnt_d;
        end
    end

    assign msb_o = buf_q[N-1];
    assign cnt_o = cnt_q;

endmodule

// File: rtl/toeplitz_sched.sv
// Sequencer between a raw entropy source and the toeplitz core: fill, prime, stream, capture.
module toeplitz_sched
    import toeplitz_pkg::*;
#(
    parameter int unsigned N    = ToepN,
    parameter int unsigned L    = ToepL,
    parameter int unsigned QTMO = 16,
    parameter int unsigned CW   = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          src_bit,
    input  logic          src_valid,
    output logic          src_ready,
    output logic          core_rst,
    output logic          core_data,
    input  logic [L-1:0]  core_q,
    input  logic          core_qstrobe,
    output logic [L-1:0]  out_q,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] blk_cnt,
    output logic          err,
    output logic          busy
);

    localparam int unsigned CntW = $clog2(N + 1);
    localparam int unsigned TmoW = $clog2(QTMO + 1);

    tsched_state_t   state_q, state_d;
    logic            src_ready_q, src_ready_d;
    logic            core_rst_q, core_rst_d;
    logic            core_data_q, core_data_d;
    logic [L-1:0]    out_q_q, out_q_d;
    logic            out_valid_q, out_valid_d;
    logic [CW-1:0]   blk_cnt_q, blk_cnt_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;
    logic [TmoW-1:0] tmo_q, tmo_d;

    logic            buf_load, buf_shift, buf_clr, buf_msb;
    logic [CntW-1:0] buf_cnt;
    logic            src_hs, out_hs;

    toeplitz_bitbuf #(
        .N    (N),
        .CntW (CntW)
    ) u_bitbuf (
        .clk_i   (clk),
        .rst_ni  (reset),
        .load_i  (buf_load),
        .bit_i   (src_bit),
        .shift_i (buf_shift),
        .clr_i   (buf_clr),
        .msb_o   (buf_msb),
        .cnt_o   (buf_cnt)
    );

    assign src_hs = src_valid & src_ready_q;
    assign out_hs = out_valid_q & out_ready;

    // FSM next-state plus next values of every registered output.
    always_comb begin
        state_d     = state_q;
        core_rst_d  = 1'b0;
        core_data_d = 1'b0;
        out_q_d     = out_q_q;
        out_valid_d = out_valid_q;
        blk_cnt_d   = blk_cnt_q;
        err_d       = err_q;
        tmo_d       = tmo_q;
        buf_load    = 1'b0;
        buf_shift   = 1'b0;
        buf_clr     = 1'b0;

        if (out_hs) begin
            out_valid_d = 1'b0;
            blk_cnt_d   = blk_cnt_q + CW'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (en && !err_q) begin
                    state_d = StFill;
                end
            end
            StFill: begin
                if (src_hs) begin
                    buf_load = 1'b1;
                end
                if (src_hs && buf_cnt == CntW'(N - 1)) begin
                    buf_clr = 1'b1;
                    state_d = StPrime;
                    // Pulse the core reset right away when the output slot is already free.
                    core_rst_d = !out_valid_q;
                end else if (!en) begin
                    // Partial fill is kept in the buffer; resume from IDLE later.
                    state_d = StIdle;
                end
            end
            StPrime: begin
                if (core_rst_q) begin
                    // Reset pulse is on the wire now; first bit goes out next cycle.
                    buf_shift   = 1'b1;
                    core_data_d = buf_msb;
                    state_d     = StStream;
                end else if (!out_valid_q) begin
                    core_rst_d = 1'b1;
                end
            end
            StStream: begin
                if (buf_cnt == CntW'(N)) begin
                    buf_clr = 1'b1;
                    tmo_d   = TmoW'(1);
                    state_d = StWaitq;
                end else begin
                    buf_shift   = 1'b1;
                    core_data_d = buf_msb;
                end
            end
            StWaitq: begin
                if (core_qstrobe) begin
                    out_q_d     = core_q;
                    out_valid_d = 1'b1;
                    state_d     = en ? StFill : StIdle;
                end else begin
                    // tmo counts cycles elapsed since the last streamed bit.
                    tmo_d = tmo_q + TmoW'(1);
                    if (tmo_d == TmoW'(QTMO)) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        src_ready_d = (state_d == StFill);
        busy_d      = (state_d != StIdle);
    end

    // State and output registers; the core is held in reset while we are.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            src_ready_q <= 1'b0;
            core_rst_q  <= 1'b1;
            core_data_q <= 1'b0;
            out_q_q     <= '0;
            out_valid_q <= 1'b0;
            blk_cnt_q   <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            src_ready_q <= src_ready_d;
            core_rst_q  <= core_rst_d;
            core_data_q <= core_data_d;
            out_q_q     <= out_q_d;
            out_valid_q <= out_valid_d;
            blk_cnt_q   <= blk_cnt_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            tmo_q       <= tmo_d;
        end
    end

    assign src_ready = src_ready_q;
    assign core_rst  = core_rst_q;
    assign core_data = core_data_q;
    assign out_q     = out_q_q;
    assign out_valid = out_valid_q;
    assign blk_cnt   = blk_cnt_q;
    assign err       = err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_toeplitz_sched.sv
// Randomized bench for toeplitz_sched with a behavioural Toeplitz core and scoreboard.
module tb_toeplitz_sched;

    localparam int unsigned N    = 256;
    localparam int unsigned L    = 128;
    localparam int unsigned QTMO = 16;
    localparam int unsigned CW   = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          en = 1'b0;
    logic          src_bit = 1'b0;
    logic          src_valid = 1'b0;
    logic          src_ready;
    logic          core_rst;
    logic          core_data;
    logic [L-1:0]  core_q = '0;
    logic          core_qstrobe = 1'b0;
    logic [L-1:0]  out_q;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] blk_cnt;
    logic          err;
    logic          busy;

    always #5 clk = ~clk;

    toeplitz_sched #(
        .N    (N),
        .L    (L),
        .QTMO (QTMO),
        .CW   (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .src_bit      (src_bit),
        .src_valid    (src_valid),
        .src_ready    (src_ready),
        .core_rst     (core_rst),
        .core_data    (core_data),
        .core_q       (core_q),
        .core_qstrobe (core_qstrobe),
        .out_q        (out_q),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .blk_cnt      (blk_cnt),
        .err          (err),
        .busy         (busy)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [L-1:0] got, input logic [L-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // ---------------- reference model state ----------------
    logic [N+L-2:0] seed;
    logic [N-1:0]   src_q[$];
    logic [L-1:0]   exp_q[$];
    logic [N-1:0]   cur_blk;
    int             bit_idx = 0;
    bit             hs_pending = 0;
    int             ready_mode = 0;  // 0 always ready, 1 random, 2 hold off
    bit             gap_en = 0;
    bit             stub = 0;
    bit             spur_en = 0;
    bit             collecting = 0;
    int             coll_idx = 0;
    logic [N-1:0]   coll_v;
    bit             pending = 0;
    int             lat_cnt = 0;
    logic [L-1:0]   hash_val;
    logic           prev_core_rst = 1'b1;
    bit             prev_rise = 0;
    bit             rise_now = 0;
    int             gap_err = 0;
    int             rstw_err = 0;
    int             cyc = 0;
    int             last_cyc = 0;
    int             err_cyc = 0;
    bit             err_seen = 0;
    int             delivered = 0;

    // Toeplitz matrix T[i][j] = seed[i - j + N - 1], y = T * x over GF(2).
    function automatic logic [L-1:0] toep(input logic [N-1:0] x);
        logic [L-1:0] y;
        logic acc;
        y = '0;
        for (int i = 0; i < L; i++) begin
            acc = 1'b0;
            for (int j = 0; j < N; j++) acc ^= seed[i - j + N - 1] & x[j];
            y[i] = acc;
        end
        return y;
    endfunction

    function automatic logic [L-1:0] rand_l();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic push_block();
        logic [N-1:0] b;
        for (int w = 0; w < N / 32; w++) b[w*32 +: 32] = $urandom;
        src_q.push_back(b);
        exp_q.push_back(toep(b));
    endtask

    // Source, sink and core behaviour, all evaluated away from the active edge.
    always @(negedge clk) begin
        cyc++;
        rise_now = 0;
        if (!reset) begin
            hs_pending   = 0;
            collecting   = 0;
            pending      = 0;
            core_qstrobe = 1'b0;
            src_valid    = 1'b0;
            delivered    = 0;
            bit_idx      = 0;
        end else begin
            // source: account for the handshake at the edge just passed
            if (hs_pending) begin
                bit_idx++;
                if (bit_idx == N) begin
                    void'(src_q.pop_front());
                    bit_idx = 0;
                end
            end
            if (src_q.size() > 0) begin
                cur_blk   = src_q[0];
                src_bit   = cur_blk[N-1-bit_idx];
                src_valid = gap_en ? ($urandom_range(0, 9) >= 3) : 1'b1;
            end else begin
                src_valid = 1'b0;
            end
            hs_pending = src_valid && src_ready;

            // sink + scoreboard
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 9) < 6);
                default: out_ready = 1'b0;
            endcase
            if (out_valid && out_ready) begin
                if (exp_q.size() > 0) check_eq("out_q", out_q, exp_q.pop_front());
                else check_eq("unexpected_result", L'(exp_q.size()), L'(1));
                delivered++;
            end

            // core: one-cycle reset pulse, then N contiguous data bits, then qstrobe
            core_qstrobe = 1'b0;
            core_q       = rand_l();
            if (pending) begin
                if (lat_cnt == 0) begin
                    core_qstrobe = 1'b1;
                    core_q       = hash_val;
                    pending      = 0;
                end else begin
                    lat_cnt--;
                end
            end else if (spur_en && !collecting && $urandom_range(0, 3) == 0) begin
                core_qstrobe = 1'b1;
            end
            rise_now = core_rst && !prev_core_rst;
            if (prev_rise && core_rst) rstw_err++;
            if (rise_now) begin
                collecting = 1;
                coll_idx   = 0;
                pending    = 0;
            end else if (collecting) begin
                coll_v = {coll_v[N-2:0], core_data};
                coll_idx++;
                if (coll_idx == N) begin
                    collecting = 0;
                    last_cyc   = cyc;
                    if (!stub) begin
                        pending  = 1;
                        lat_cnt  = $urandom_range(0, 7);
                        hash_val = toep(coll_v);
                    end
                end
            end else if (core_data) begin
                gap_err++;
            end
            if (err && !err_seen) begin
                err_seen = 1;
                err_cyc  = cyc;
            end
        end
        prev_core_rst = core_rst;
        prev_rise     = rise_now;
    end

    task automatic wait_deliv(input string tag, input int target, input int budget);
        for (int i = 0; i < budget && delivered < target; i++) begin
            @(posedge clk);
            #2;
        end
        check_eq(tag, L'(delivered), L'(target));
    endtask

    task automatic check_reset_vals(input string pfx);
        check_eq({pfx, "_src_ready"}, L'(src_ready), L'(0));
        check_eq({pfx, "_core_rst"}, L'(core_rst), L'(1));
        check_eq({pfx, "_core_data"}, L'(core_data), L'(0));
        check_eq({pfx, "_out_q"}, out_q, L'(0));
        check_eq({pfx, "_out_valid"}, L'(out_valid), L'(0));
        check_eq({pfx, "_blk_cnt"}, L'(blk_cnt), L'(0));
        check_eq({pfx, "_err"}, L'(err), L'(0));
        check_eq({pfx, "_busy"}, L'(busy), L'(0));
    endtask

    initial begin
        int bad;
        int idx_saved;
        seed = {rand_l(), rand_l(), rand_l()};
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst");
        @(posedge clk);
        #2;
        reset = 1'b1;

        // single block, no gaps
        en = 1'b1;
        ready_mode = 0;
        push_block();
        wait_deliv("blk1_deliv", 1, 2000);
        check_eq("blk1_cnt", L'(blk_cnt), L'(1));

        // three more with source gaps and random consumer
        gap_en = 1;
        ready_mode = 1;
        repeat (3) push_block();
        wait_deliv("blk4_deliv", 4, 6000);
        check_eq("blk4_cnt", L'(blk_cnt), L'(4));

        // backpressure: result held, next block must stall in PRIME
        ready_mode = 2;
        repeat (2) push_block();
        for (int i = 0; i < 4000 && !(src_q.size() == 0 && out_valid); i++) begin
            @(posedge clk);
            #2;
        end
        repeat (4) @(posedge clk);
        #2;
        spur_en = 1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #2;
            if (!busy || core_rst || collecting || !out_valid) bad++;
        end
        spur_en = 0;
        check_eq("stall_prime", L'(bad), L'(0));
        ready_mode = 0;
        wait_deliv("bp_deliv", 6, 3000);
        check_eq("bp_cnt", L'(blk_cnt), L'(6));

        // async reset in the middle of streaming
        push_block();
        for (int i = 0; i < 3000 && !(collecting && coll_idx >= 100); i++) begin
            @(posedge clk);
            #2;
        end
        reset = 1'b0;
        #1;
        check_reset_vals("midrst");
        exp_q.delete();
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        push_block();
        wait_deliv("post_rst_deliv", 1, 3000);
        check_eq("post_rst_cnt", L'(blk_cnt), L'(1));

        // en drop part-way through a fill
        ready_mode = 1;
        push_block();
        for (int i = 0; i < 2000 && bit_idx < 50; i++) begin
            @(posedge clk);
            #2;
        end
        en = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check_eq("en_drop_src_ready", L'(src_ready), L'(0));
        check_eq("en_drop_busy", L'(busy), L'(0));
        idx_saved = bit_idx;
        repeat (10) @(posedge clk);
        #2;
        check_eq("en_drop_hold", L'(bit_idx), L'(idx_saved));
        en = 1'b1;
        wait_deliv("en_drop_deliv", 2, 3000);
        check_eq("en_drop_cnt", L'(blk_cnt), L'(2));

        // qstrobe never arrives
        stub = 1;
        push_block();
        for (int i = 0; i < 3000 && !err_seen; i++) begin
            @(posedge clk);
            #2;
        end
        check_eq("tmo_err", L'(err), L'(1));
        check_eq("tmo_delay", L'(err_cyc - last_cyc), L'(QTMO));
        exp_q.delete();
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #2;
            if (src_ready || busy || !err) bad++;
        end
        check_eq("tmo_sticky_idle", L'(bad), L'(0));

        check_eq("core_data_gaps", L'(gap_err), L'(0));
        check_eq("core_rst_width", L'(rstw_err), L'(0));
        check_eq("results_pending", L'(exp_q.size()), L'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
